// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with a parameterised frame format and a small
// first-word fall-through receive FIFO. Errored frames are reported and discarded.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          sampleclk,
   input  logic                          reset,
   input  logic                          uart_rx,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overrun
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic              ODD_PAR   = (PARITY == 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } state_t;

   // Line synchronizer; resets to the idle level so no false start is seen.
   logic [1:0] sync_reg;
   logic       rx_s;

   always_ff @(posedge sampleclk or negedge reset) begin
      if (!reset) sync_reg <= 2'b11;
      else        sync_reg <= {sync_reg[0], uart_rx};
   end

   assign rx_s = sync_reg[1];

   state_t                 state_reg, state_next;
   logic [TICK_W-1:0]      tick_reg, tick_next;
   logic [BIT_W-1:0]       bit_reg, bit_next;
   logic [DATA_BITS-1:0]   shift_reg, shift_next;
   logic                   perr_reg, perr_next;
   logic                   push_reg, push_next;
   logic                   frame_err_reg, frame_err_next;
   logic                   parity_err_reg, parity_err_next;

   always_ff @(posedge sampleclk or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         tick_reg       <= '0;
         bit_reg        <= '0;
         shift_reg      <= '0;
         perr_reg       <= 1'b0;
         push_reg       <= 1'b0;
         frame_err_reg  <= 1'b0;
         parity_err_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         tick_reg       <= tick_next;
         bit_reg        <= bit_next;
         shift_reg      <= shift_next;
         perr_reg       <= perr_next;
         push_reg       <= push_next;
         frame_err_reg  <= frame_err_next;
         parity_err_reg <= parity_err_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      tick_next       = tick_reg + 1'b1;
      bit_next        = bit_reg;
      shift_next      = shift_reg;
      perr_next       = perr_reg;
      push_next       = 1'b0;
      frame_err_next  = 1'b0;
      parity_err_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            tick_next = '0;
            if (!rx_s) begin
               state_next = ST_START;
               bit_next   = '0;
               perr_next  = 1'b0;
            end
         end
         ST_START: begin
            // Re-check the line half a bit in; a short low pulse is a glitch.
            if (tick_reg == TICK_HALF) begin
               tick_next  = '0;
               state_next = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick_reg == TICK_LAST) begin
               tick_next  = '0;
               shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
               bit_next   = bit_reg + 1'b1;
               if (bit_reg == BIT_LAST)
                  state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (tick_reg == TICK_LAST) begin
               tick_next  = '0;
               perr_next  = (^shift_reg) ^ rx_s ^ ODD_PAR;
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            // Frame verdict is registered and acted on in the following cycle.
            if (tick_reg == TICK_LAST) begin
               tick_next       = '0;
               push_next       = rx_s & ~perr_reg;
               frame_err_next  = ~rx_s;
               parity_err_next = perr_reg;
               state_next      = rx_s ? ST_IDLE : ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            tick_next = '0;
            if (rx_s) state_next = ST_IDLE;
         end
         default: begin
            tick_next  = '0;
            state_next = ST_IDLE;
         end
      endcase
   end

   assign parity_err = parity_err_reg;
   assign frame_err  = frame_err_reg;

   // Receive FIFO: storage is not reset, the head is masked while empty.
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]     count_reg;
   logic                 overrun_reg;
   logic                 pop, full, wr_en, drop;

   assign pop   = rd_en & (count_reg != '0);
   assign full  = (count_reg == CNT_FULL);
   assign wr_en = push_reg & (~full | pop);
   assign drop  = push_reg & full & ~pop;

   always_ff @(posedge sampleclk) begin
      if (wr_en) mem[wr_ptr_reg] <= shift_reg;
   end

   always_ff @(posedge sampleclk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         overrun_reg <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({wr_en, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (drop)     overrun_reg <= 1'b1;
         else if (pop) overrun_reg <= 1'b0;
      end
   end

   assign rx_valid   = (count_reg != '0);
   assign rx_data    = rx_valid ? mem[rd_ptr_reg] : '0;
   assign fifo_count = count_reg;
   assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: a default 8N1 receiver and an even-parity
// receiver are driven with directed frames; popped words are checked in order.
module tb_uart_rx_param;

   logic       sampleclk = 1'b0;
   logic       reset = 1'b0;
   logic       line0 = 1'b1, line1 = 1'b1;
   logic       rd0 = 1'b0, rd1 = 1'b0;
   logic [7:0] data0, data1;
   logic       v0, v1;
   logic [2:0] cnt0, cnt1;
   logic       pe0, pe1, fe0, fe1, ov0, ov1;

   always #5 sampleclk = ~sampleclk;

   uart_rx_param dut (
      .sampleclk(sampleclk), .reset(reset), .uart_rx(line0), .rd_en(rd0),
      .rx_data(data0), .rx_valid(v0), .fifo_count(cnt0),
      .parity_err(pe0), .frame_err(fe0), .overrun(ov0)
   );

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .FIFO_DEPTH(4)) dut_par (
      .sampleclk(sampleclk), .reset(reset), .uart_rx(line1), .rd_en(rd1),
      .rx_data(data1), .rx_valid(v1), .fifo_count(cnt1),
      .parity_err(pe1), .frame_err(fe1), .overrun(ov1)
   );

   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] exp0[$];
   logic [7:0] exp1[$];
   int         fe_cnt0 = 0, pe_cnt0 = 0, fe_cnt1 = 0, pe_cnt1 = 0, both_cnt1 = 0;
   int         lat = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
   endtask

   // Monitor: counts error pulses and checks every accepted pop against the queue.
   always @(negedge sampleclk) begin
      if (fe0) fe_cnt0++;
      if (pe0) pe_cnt0++;
      if (fe1) fe_cnt1++;
      if (pe1) pe_cnt1++;
      if (fe1 && pe1) both_cnt1++;
      if (v0 && rd0) begin
         if (exp0.size() == 0) begin
            n_checks++;
            $display("FAIL pop0_unexpected: got 0x%0h, expected no data", data0);
         end else begin
            chk("pop0_data", data0, exp0.pop_front());
         end
      end
      if (v1 && rd1) begin
         if (exp1.size() == 0) begin
            n_checks++;
            $display("FAIL pop1_unexpected: got 0x%0h, expected no data", data1);
         end else begin
            chk("pop1_data", data1, exp1.pop_front());
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge sampleclk);
      #1;
   endtask

   task automatic set_line(input int which, input logic v);
      if (which == 0) line0 = v;
      else            line1 = v;
   endtask

   // Drives one frame at 16 cycles per bit; a 0 stop bit leaves the line low.
   task automatic send_frame(input int which, input logic [7:0] d, input logic use_par,
                             input logic par_bit, input logic stop_bit);
      set_line(which, 1'b0);
      wait_cyc(16);
      for (int i = 0; i < 8; i++) begin
         set_line(which, d[i]);
         wait_cyc(16);
      end
      if (use_par) begin
         set_line(which, par_bit);
         wait_cyc(16);
      end
      set_line(which, stop_bit);
      wait_cyc(16);
   endtask

   task automatic read_one(input int which);
      if (which == 0) rd0 = 1'b1;
      else            rd1 = 1'b1;
      wait_cyc(1);
      rd0 = 1'b0;
      rd1 = 1'b0;
   endtask

   initial begin
      logic [7:0] fill_a [5];
      logic [7:0] fill_b [5];
      fill_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      fill_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

      repeat (3) @(posedge sampleclk);
      @(negedge sampleclk);
      chk("rst_valid", v0, 0);
      chk("rst_count", cnt0, 0);
      chk("rst_data", data0, 0);
      chk("rst_err_flags", {pe0, fe0, ov0}, 0);
      chk("rst_valid_par", v1, 0);
      @(posedge sampleclk);
      #1 reset = 1'b1;
      wait_cyc(4);

      // 0xA5 8N1 with latency bound from the start edge
      exp0.push_back(8'hA5);
      lat = 0;
      fork
         send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
         begin
            while (!v0 && lat < 200) begin
               wait_cyc(1);
               lat++;
            end
         end
      join
      n_checks++;
      if (v0 && lat <= 156) n_pass++;
      else $display("FAIL latency_a5: got %0d cycles (valid=%0b), required <= 156", lat, v0);
      chk("a5_count", cnt0, 1);
      chk("a5_head", data0, 8'hA5);
      wait_cyc(8);
      chk("a5_head_stable", data0, 8'hA5);
      chk("a5_no_err_pulses", fe_cnt0 + pe_cnt0, 0);
      read_one(0);
      chk("a5_count_after_pop", cnt0, 0);
      rd0 = 1'b1;
      wait_cyc(2);
      rd0 = 1'b0;
      chk("empty_rd_count", cnt0, 0);
      chk("empty_rd_valid", v0, 0);

      // 5-tick glitch is rejected, the next frame still arrives
      line0 = 1'b0;
      wait_cyc(5);
      line0 = 1'b1;
      wait_cyc(40);
      chk("glitch_valid", v0, 0);
      chk("glitch_count", cnt0, 0);
      exp0.push_back(8'h3C);
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
      wait_cyc(4);
      chk("post_glitch_count", cnt0, 1);
      read_one(0);

      // 0x55 with bad stop bit then a 40 bit-time break
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
      wait_cyc(640);
      line0 = 1'b1;
      wait_cyc(32);
      chk("break_fe_pulses", fe_cnt0, 1);
      chk("break_count", cnt0, 0);
      exp0.push_back(8'h81);
      send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
      wait_cyc(4);
      chk("post_break_count", cnt0, 1);
      read_one(0);
      chk("post_break_fe_pulses", fe_cnt0, 1);

      // Five frames into a 4-deep FIFO with no reads
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp0.push_back(fill_a[i]);
         send_frame(0, fill_a[i], 1'b0, 1'b0, 1'b1);
         wait_cyc(4);
      end
      chk("full_count", cnt0, 4);
      chk("full_overrun", ov0, 1);
      read_one(0);
      chk("overrun_cleared", ov0, 0);
      chk("count_after_first_pop", cnt0, 3);
      for (int i = 0; i < 3; i++) read_one(0);
      chk("drained_count", cnt0, 0);

      // Full FIFO with a pop in the push cycle
      for (int i = 0; i < 4; i++) begin
         exp0.push_back(fill_b[i]);
         send_frame(0, fill_b[i], 1'b0, 1'b0, 1'b1);
         wait_cyc(4);
      end
      exp0.push_back(fill_b[4]);
      fork
         send_frame(0, fill_b[4], 1'b0, 1'b0, 1'b1);
         begin
            wait_cyc(lat - 1);
            rd0 = 1'b1;
            wait_cyc(1);
            rd0 = 1'b0;
         end
      join
      wait_cyc(4);
      chk("full_rw_count", cnt0, 4);
      chk("full_rw_overrun", ov0, 0);
      for (int i = 0; i < 4; i++) read_one(0);
      chk("full_rw_drained", cnt0, 0);

      // Even parity receiver
      send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
      wait_cyc(4);
      chk("par_bad_pe_pulses", pe_cnt1, 1);
      chk("par_bad_count", cnt1, 0);
      exp1.push_back(8'h03);
      send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
      wait_cyc(4);
      chk("par_good_count", cnt1, 1);
      chk("par_good_pe_pulses", pe_cnt1, 1);
      read_one(1);
      exp1.push_back(8'h07);
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
      wait_cyc(4);
      chk("par_07_count", cnt1, 1);
      read_one(1);
      send_frame(1, 8'h07, 1'b1, 1'b0, 1'b0);
      wait_cyc(16);
      line1 = 1'b1;
      wait_cyc(32);
      chk("par_both_pe_pulses", pe_cnt1, 2);
      chk("par_both_fe_pulses", fe_cnt1, 1);
      chk("par_both_same_cycle", both_cnt1, 1);
      chk("par_both_count", cnt1, 0);

      // Reset mid-frame with one word held
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
      wait_cyc(4);
      chk("pre_reset_count", cnt0, 1);
      line0 = 1'b0;
      wait_cyc(60);
      #3 reset = 1'b0;
      #2;
      chk("async_rst_count", cnt0, 0);
      chk("async_rst_valid", v0, 0);
      chk("async_rst_data", data0, 0);
      line0 = 1'b1;
      wait_cyc(3);
      @(negedge sampleclk) reset = 1'b1;
      wait_cyc(40);
      chk("post_reset_count", cnt0, 0);
      chk("post_reset_fe_pulses", fe_cnt0, 1);
      exp0.push_back(8'h96);
      send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1);
      wait_cyc(4);
      chk("post_reset_rx_count", cnt0, 1);
      read_one(0);

      chk("exp0_drained", exp0.size(), 0);
      chk("exp1_drained", exp1.size(), 0);
      chk("par_overrun", ov1, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter: DATA_BITS, default 8, data bits per frame, legal range 5..8.
REQ-002 Parameter: OVERSAMPLE, default 16, sampleclk ticks per bit, even, legal range 8..64.
REQ-003 Parameter: PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter: FIFO_DEPTH, default 4, receive FIFO entries, power of 2, legal range 2..16.
REQ-005 Port: sampleclk  input  1  sampling clock, rising edge active.
REQ-006 Port: reset  input  1  asynchronous, active-low reset.
REQ-007 Port: uart_rx  input  1  serial line, idle high, asynchronous to sampleclk.
REQ-008 Port: rd_en  input  1  pop request; consumes the FIFO head when rx_valid=1.
REQ-009 Port: rx_data  output  DATA_BITS  FIFO head, first-word fall-through.
REQ-010 Port: rx_valid  output  1  FIFO non-empty.
REQ-011 Port: fifo_count  output  $clog2(FIFO_DEPTH)+1  number of entries held.
REQ-012 Port: parity_err  output  1  one-cycle pulse on a completed frame with bad parity.
REQ-013 Port: frame_err  output  1  one-cycle pulse on a completed frame with stop bit sampled 0.
REQ-014 Port: overrun  output  1  sticky; set when a frame is dropped because the FIFO is full.

Function
REQ-015 uart_rx shall pass through a 2-flop synchronizer; all logic below uses the synchronized value rx_s.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 IDLE: rx_s=0 -> START and tick counter cleared; otherwise remain.
REQ-018 START: at tick OVERSAMPLE/2-1, rx_s=1 -> IDLE (glitch reject, nothing pushed); rx_s=0 -> DATA and tick counter cleared.
REQ-019 DATA: sample rx_s every OVERSAMPLE ticks (bit centre); LSB first into a shift register; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-020 PARITY: sample after OVERSAMPLE ticks; error if XOR(data, parity bit) is 1 for even or 0 for odd.
REQ-021 STOP: sample after OVERSAMPLE ticks; rx_s=1 -> IDLE; rx_s=0 -> frame_err and WAIT_HIGH.
REQ-022 WAIT_HIGH: remain until rx_s=1, then -> IDLE (break conditions produce one frame_err only).
REQ-023 Push: in the cycle after the stop-bit sample, the data word shall be written to the FIFO only if stop=1 and no parity error; errored frames are discarded.
REQ-024 parity_err and frame_err shall pulse high for exactly one cycle in the push cycle; both may pulse together.
REQ-025 rx_valid shall rise the cycle after the push; rx_data shall be stable while rx_valid=1 and rd_en=0.
REQ-026 rd_en while empty: ignored; no count underflow.
REQ-027 Push while full with no pop: frame dropped, FIFO unchanged, overrun set.
REQ-028 Push while full with rd_en=1: pop and push both occur, count unchanged, no overrun.
REQ-029 overrun shall clear on the first accepted pop after it is set.
REQ-030 FIFO pointers shall wrap modulo FIFO_DEPTH; fifo_count shall never exceed FIFO_DEPTH.

Reset
REQ-031 reset=0 asynchronously forces: FSM IDLE, counters 0, FIFO empty, rx_data=0, rx_valid=0, fifo_count=0, parity_err=0, frame_err=0, overrun=0; synchronizer flops = 1.
REQ-032 Reset during a frame shall abort it with nothing pushed; after release, the next falling edge of rx_s is treated as a new start bit.

Verification
REQ-033 Defaults, send 0xA5 8N1 at 16 ticks/bit -> rx_data=0xA5, rx_valid=1 within 9.5*16+4 cycles of the start edge, no error pulses.
REQ-034 Low pulse of 5 ticks on idle line -> no push, FSM back in IDLE, rx_valid stays 0.
REQ-035 PARITY=1, send 0x03 with parity bit 1 -> parity_err pulse, nothing pushed; with parity bit 0 -> 0x03 pushed.
REQ-036 Send 0x55 with stop bit 0, then hold line low 40 bit-times -> exactly one frame_err pulse, no push, receives normally after line returns high.
REQ-037 FIFO_DEPTH=4, send 5 bytes without rd_en -> fifo_count=4, overrun=1, first 4 bytes read in order, overrun clears on first pop.
REQ-038 Full FIFO with rd_en=1 in the push cycle -> count stays 4, overrun stays 0, ordering preserved.
